pipeline_stall_ctrl: RTL

Sequences pipeline-register enables and flushes for the 5-stage RV32I core. It resolves load-use stalls, taken-branch/jump flushes in EX, and data-memory wait states with a timeout. It sits beside the EX-stage forwarding selector and drives the write enables of PC, IF/ID, ID/EX, EX/MA and MA/WB. Forwarding covers every RAW case except load-use and memory wait; this block handles those.

---
 rtl/pipeline_stall_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline enable/flush sequencer for the 5-stage RV32I core: load-use stalls, EX branch flushes,
// data-memory wait states with timeout. Optional stall counter built when STALL_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_EX,
    input  logic [4:0]  RD_EX,
    input  logic [4:0]  RS1_ID,
    input  logic [4:0]  RS2_ID,
    input  logic        UseRS1_ID,
    input  logic        UseRS2_ID,
    input  logic        BrTaken_EX,
    input  logic        DmemReq_MA,
    input  logic        DmemReady,
    output logic        PCWEn,
    output logic        IF_ID_WEn,
    output logic        ID_EX_WEn,
    output logic        EX_MA_WEn,
    output logic        MA_WB_WEn,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        MemErr,
    output logic [31:0] StallCycles
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

    state_t     state_reg;
    logic [7:0] wait_cnt_reg;
    logic [7:0] wait_cnt_next;
    logic       mem_err_reg;
    logic       freeze;
    logic       load_use;

    always_comb begin
        freeze = ((state_reg == MEM_WAIT) && !DmemReady) ||
                 ((state_reg == RUN) && DmemReq_MA && !DmemReady) ||
                 (state_reg == ERROR);
        load_use = MemRead_EX && (RD_EX != 5'd0) &&
                   ((UseRS1_ID && (RD_EX == RS1_ID)) || (UseRS2_ID && (RD_EX == RS2_ID)));
        wait_cnt_next = wait_cnt_reg + 8'd1;
    end

    // Priority: reset > freeze > taken branch > load-use > normal flow.
    always_comb begin
        PCWEn       = 1'b1;
        IF_ID_WEn   = 1'b1;
        ID_EX_WEn   = 1'b1;
        EX_MA_WEn   = 1'b1;
        MA_WB_WEn   = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        if (reset) begin
            {PCWEn, IF_ID_WEn, ID_EX_WEn, EX_MA_WEn, MA_WB_WEn} = 5'b00000;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (freeze) begin
            {PCWEn, IF_ID_WEn, ID_EX_WEn, EX_MA_WEn, MA_WB_WEn} = 5'b00000;
        end else if (BrTaken_EX) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (load_use) begin
            PCWEn       = 1'b0;
            IF_ID_WEn   = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
            mem_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (DmemReq_MA && !DmemReady) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (DmemReady) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= 8'd0;
                    end else if (wait_cnt_next == TIMEOUT_W) begin
                        state_reg    <= ERROR;
                        wait_cnt_reg <= 8'd0;
                        mem_err_reg  <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                    end
                end
                default: begin
                    state_reg   <= ERROR;
                    mem_err_reg <= 1'b1;
                end
            endcase
        end
    end

    assign MemErr = mem_err_reg && !reset;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= 32'd0;
        end else if (!PCWEn && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign StallCycles = reset ? 32'd0 : stall_cnt_reg;
`else
    assign StallCycles = 32'd0;
`endif

endmodule
